// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// the arbiter state encoding and the default bus-wait timeout.
package mem_port_arbiter_pkg;

    localparam int TIMEOUT_CYC_DEFAULT = 16;
    localparam int TIMER_W             = 8;

    typedef enum logic [1:0] {
        IDLE,
        DM_ACC,
        IF_ACC,
        RESP
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Bus wait timer: counts cycles the arbiter spends waiting on the bus and
// flags the cycle in which the LIMIT-th unanswered wait cycle occurs.
module bus_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is qualified by enable so a cycle with bus_ready_i never aborts.
    assign expired_o = enable_i && (count_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch stage and the memory
// stage: data has priority, but fetch is guaranteed the grant after a data access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_valid_o,
    input  logic            dm_read_i,
    input  logic            dm_write_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic [XLEN-1:0] dm_rdata_o,
    output logic            dm_valid_o,
    output logic            stall_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_ready_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    output logic            err_o
);

    arb_state_e      state_q;
    logic            bus_req_q;
    logic            bus_we_q;
    logic            if_valid_q;
    logic            dm_valid_q;
    logic            err_q;
    logic            fetch_next_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic dm_req;
    logic in_access;
    logic timed_out;

    assign dm_req    = dm_read_i | dm_write_i;
    assign in_access = (state_q == DM_ACC) || (state_q == IF_ACC);

    bus_wait_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (!in_access),
        .enable_i (in_access && !bus_ready_i),
        .expired_o(timed_out)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            fetch_next_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    fetch_next_q <= 1'b0;
                    // A pending fairness flag lets fetch jump ahead of a new data request.
                    if (if_req_i && (fetch_next_q || !dm_req)) begin
                        addr_q    <= if_addr_i;
                        bus_we_q  <= 1'b0;
                        bus_req_q <= 1'b1;
                        state_q   <= IF_ACC;
                    end else if (dm_req) begin
                        addr_q    <= dm_addr_i;
                        wdata_q   <= dm_wdata_i;
                        bus_we_q  <= dm_write_i;
                        bus_req_q <= 1'b1;
                        state_q   <= DM_ACC;
                    end
                end
                DM_ACC, IF_ACC: begin
                    if (bus_ready_i || timed_out) begin
                        rdata_q   <= bus_ready_i ? bus_rdata_i : '0;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        state_q   <= RESP;
                        if (!bus_ready_i) begin
                            err_q <= 1'b1;
                        end
                        if (state_q == DM_ACC) begin
                            dm_valid_q   <= 1'b1;
                            fetch_next_q <= if_req_i;
                        end else begin
                            if_valid_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o  = rdata_q;
    assign dm_rdata_o  = rdata_q;
    assign if_valid_o  = if_valid_q;
    assign dm_valid_o  = dm_valid_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign err_o       = err_q;

    // Stall is combinational on the requests and is forced low while in reset.
    assign stall_o = reset_i &&
                     ((if_req_i && !if_valid_q) || (dm_req && !dm_valid_q));

endmodule
